// File: rtl/vend_pkg.sv
// -----------------------------------------------------------------------------
// vend_pkg
// Shared definitions for the vending money paths (coin acceptance and change
// dispensing): denomination values, the dispense state encoding and the
// one-hot coin index type.
// No ports (package).
// -----------------------------------------------------------------------------
package vend_pkg;

    localparam int DENOM_1  = 1;
    localparam int DENOM_5  = 5;
    localparam int DENOM_10 = 10;
    localparam int DENOM_20 = 20;

    // Bit positions inside a one-hot coin index.
    localparam int COIN_IDX_1  = 0;
    localparam int COIN_IDX_5  = 1;
    localparam int COIN_IDX_10 = 2;
    localparam int COIN_IDX_20 = 3;

    // One-hot coin index: bit0=1, bit1=5, bit2=10, bit3=20.
    typedef logic [3:0] coin_oh_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SELECT = 3'd1,
        ST_PULSE  = 3'd2,
        ST_GAP    = 3'd3,
        ST_DONE   = 3'd4
    } disp_state_e;

endpackage

// File: rtl/dispense_timer.sv
// -----------------------------------------------------------------------------
// dispense_timer
// Loadable down-counter that times both the eject pulse and the gap that
// follows it. Loading value N makes o_expired rise N cycles later; the counter
// parks at zero once expired.
// Ports:
//   clk, i_rst     clock, asynchronous active-high reset
//   i_load         load i_load_val this cycle
//   i_load_val     cycles-minus-one to count
//   o_expired      counter is at zero
// -----------------------------------------------------------------------------
module dispense_timer #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_expired
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_expired = (r_count == '0);

endmodule

// File: rtl/change_dispenser.sv
// -----------------------------------------------------------------------------
// change_dispenser
// Pays out a requested amount as individual coin-eject pulses, greedily in
// 20/10/5/1 units, one coin per pulse+gap+reselect slot.
// Optional feature macro: INVENTORY_EN -- per-denomination stock counters fed
// by dep_* pulses; empty denominations are skipped and a residue can be left.
// Ports:
//   clk, i_rst              clock, asynchronous active-high reset
//   start, amount           request strobe and value (accepted in IDLE only)
//   busy                    high from SELECT through DONE
//   done                    one-cycle completion pulse
//   short, unpaid           residue flag/value, held until next start
//   o_ej_1..o_ej_20         coin eject pulses, at most one high
//   dep_1..dep_20           deposit pulses (INVENTORY_EN only)
// -----------------------------------------------------------------------------
module change_dispenser
    import vend_pkg::*;
#(
    parameter int AMT_W        = 8,
    parameter int PULSE_CYCLES = 2,
    parameter int GAP_CYCLES   = 4
`ifdef INVENTORY_EN
    , parameter int INIT_STOCK = 8
`endif
) (
    input  logic             clk,
    input  logic             i_rst,
    input  logic             start,
    input  logic [AMT_W-1:0] amount,
    output logic             busy,
    output logic             done,
    output logic             short,
    output logic [AMT_W-1:0] unpaid,
    output logic             o_ej_1,
    output logic             o_ej_5,
    output logic             o_ej_10,
    output logic             o_ej_20
`ifdef INVENTORY_EN
    ,
    input  logic             dep_1,
    input  logic             dep_5,
    input  logic             dep_10,
    input  logic             dep_20
`endif
);

    localparam int TMR_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [AMT_W-1:0] D1  = AMT_W'(DENOM_1);
    localparam logic [AMT_W-1:0] D5  = AMT_W'(DENOM_5);
    localparam logic [AMT_W-1:0] D10 = AMT_W'(DENOM_10);
    localparam logic [AMT_W-1:0] D20 = AMT_W'(DENOM_20);

    disp_state_e      r_state;
    logic [AMT_W-1:0] r_remaining;
    logic             r_busy;
    logic             r_done;
    logic             r_short;
    logic [AMT_W-1:0] r_unpaid;
    coin_oh_t         r_ej;

    coin_oh_t         w_stock_ok;
    coin_oh_t         w_avail;
    coin_oh_t         w_pick;
    logic [AMT_W-1:0] w_pick_val;
    logic             w_tmr_load;
    logic [TMR_W-1:0] w_tmr_val;
    logic             w_tmr_expired;

`ifdef INVENTORY_EN
    logic [7:0] r_stock [4];
    coin_oh_t   w_dep;
    coin_oh_t   w_take;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_stock_ok[i] = (r_stock[i] != 8'd0);
        end
    end

    assign w_dep  = {dep_20, dep_10, dep_5, dep_1};
    assign w_take = (r_state == ST_SELECT) ? w_pick : '0;

    // A deposit and a dispense of the same coin cancel; deposits saturate.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < 4; i++) r_stock[i] <= 8'(INIT_STOCK);
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (w_dep[i] && !w_take[i] && (r_stock[i] != 8'hFF)) begin
                    r_stock[i] <= r_stock[i] + 8'd1;
                end else if (!w_dep[i] && w_take[i]) begin
                    r_stock[i] <= r_stock[i] - 8'd1;
                end
            end
        end
    end

    localparam bit INV_EN = 1'b1;
`else
    assign w_stock_ok = 4'b1111;
    localparam bit INV_EN = 1'b0;
`endif

    assign w_avail[COIN_IDX_1]  = (r_remaining >= D1)  && w_stock_ok[COIN_IDX_1];
    assign w_avail[COIN_IDX_5]  = (r_remaining >= D5)  && w_stock_ok[COIN_IDX_5];
    assign w_avail[COIN_IDX_10] = (r_remaining >= D10) && w_stock_ok[COIN_IDX_10];
    assign w_avail[COIN_IDX_20] = (r_remaining >= D20) && w_stock_ok[COIN_IDX_20];

    // Greedy choice: largest available denomination wins.
    always_comb begin
        w_pick     = '0;
        w_pick_val = '0;
        if (w_avail[COIN_IDX_20]) begin
            w_pick[COIN_IDX_20] = 1'b1;
            w_pick_val          = D20;
        end else if (w_avail[COIN_IDX_10]) begin
            w_pick[COIN_IDX_10] = 1'b1;
            w_pick_val          = D10;
        end else if (w_avail[COIN_IDX_5]) begin
            w_pick[COIN_IDX_5] = 1'b1;
            w_pick_val         = D5;
        end else if (w_avail[COIN_IDX_1]) begin
            w_pick[COIN_IDX_1] = 1'b1;
            w_pick_val         = D1;
        end
    end

    // Timer is loaded with (cycles-1) on entry to PULSE and to GAP, so it
    // expires in the last cycle of each phase.
    assign w_tmr_load = ((r_state == ST_SELECT) && (w_pick != '0)) ||
                        ((r_state == ST_PULSE) && w_tmr_expired);
    assign w_tmr_val  = (r_state == ST_SELECT) ? TMR_W'(PULSE_CYCLES - 1)
                                               : TMR_W'(GAP_CYCLES - 1);

    dispense_timer #(
        .CNT_W (TMR_W)
    ) u_timer (
        .clk        (clk),
        .i_rst      (i_rst),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_expired  (w_tmr_expired)
    );

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_remaining <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_short     <= 1'b0;
            r_unpaid    <= '0;
            r_ej        <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_remaining <= amount;
                        r_short     <= 1'b0;
                        r_unpaid    <= '0;
                        r_busy      <= 1'b1;
                        r_state     <= ST_SELECT;
                    end
                end
                ST_SELECT: begin
                    if (w_pick != '0) begin
                        r_remaining <= r_remaining - w_pick_val;
                        r_ej        <= w_pick;
                        r_state     <= ST_PULSE;
                    end else begin
                        // Nothing payable: either fully paid or out of stock.
                        r_short  <= INV_EN && (r_remaining != '0);
                        r_unpaid <= r_remaining;
                        r_done   <= 1'b1;
                        r_state  <= ST_DONE;
                    end
                end
                ST_PULSE: begin
                    if (w_tmr_expired) begin
                        r_ej    <= '0;
                        r_state <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (w_tmr_expired) r_state <= ST_SELECT;
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign short   = r_short;
    assign unpaid  = r_unpaid;
    assign o_ej_1  = r_ej[COIN_IDX_1];
    assign o_ej_5  = r_ej[COIN_IDX_5];
    assign o_ej_10 = r_ej[COIN_IDX_10];
    assign o_ej_20 = r_ej[COIN_IDX_20];

endmodule

// File: tb/tb_change_dispenser.sv
// -----------------------------------------------------------------------------
// tb_change_dispenser
// Self-checking bench for change_dispenser. A queue-based greedy payout model
// (with optional stock tracking when INVENTORY_EN is defined) predicts the coin
// sequence, coin start cycles, done cycle, short and unpaid for each request.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_change_dispenser;

    localparam int AMT_W    = 8;
    localparam int P_CYC    = 2;
    localparam int G_CYC    = 4;
    localparam int COIN_CYC = P_CYC + G_CYC + 1;
    localparam int INIT_STK = 8;
    localparam int TIMEOUT  = 400;

`ifdef INVENTORY_EN
    localparam bit INV = 1'b1;
`else
    localparam bit INV = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             i_rst;
    logic             start;
    logic [AMT_W-1:0] amount;
    logic             busy, done, short;
    logic [AMT_W-1:0] unpaid;
    logic             o_ej_1, o_ej_5, o_ej_10, o_ej_20;
`ifdef INVENTORY_EN
    logic             dep_1, dep_5, dep_10, dep_20;
`endif

    int checks   = 0;
    int failures = 0;
    int stock [4];
    int denom_val [4] = '{1, 5, 10, 20};

    always #5 clk = ~clk;

    change_dispenser #(
        .AMT_W        (AMT_W),
        .PULSE_CYCLES (P_CYC),
        .GAP_CYCLES   (G_CYC)
    ) dut (
        .clk     (clk),
        .i_rst   (i_rst),
        .start   (start),
        .amount  (amount),
        .busy    (busy),
        .done    (done),
        .short   (short),
        .unpaid  (unpaid),
        .o_ej_1  (o_ej_1),
        .o_ej_5  (o_ej_5),
        .o_ej_10 (o_ej_10),
        .o_ej_20 (o_ej_20)
`ifdef INVENTORY_EN
        ,
        .dep_1   (dep_1),
        .dep_5   (dep_5),
        .dep_10  (dep_10),
        .dep_20  (dep_20)
`endif
    );

    task automatic model_reset();
        for (int i = 0; i < 4; i++) stock[i] = INIT_STK;
    endtask

    // One request from start strobe to the cycle after done.
    task automatic run_txn(input int amt, input bit repulse, input string nm);
        int exp_coins[$];
        int obs_coins[$];
        int obs_cyc[$];
        int rem, exp_done, cyc, ndone, done_cyc, hi_len;
        int obs_short, obs_unpaid, n;
        bit multi, badw, busy_gap, finished, busy_after, held_bad;
        logic [3:0] prev, cur;

        rem = amt;
        for (int i = 3; i >= 0; i--) begin
            while (rem >= denom_val[i] && (!INV || stock[i] > 0)) begin
                exp_coins.push_back(denom_val[i]);
                rem -= denom_val[i];
                if (INV) stock[i]--;
            end
        end
        exp_done = 2 + exp_coins.size() * COIN_CYC;

        ndone = 0; done_cyc = -1; hi_len = 0; obs_short = -1; obs_unpaid = -1;
        multi = 0; badw = 0; busy_gap = 0; finished = 0; busy_after = 1; held_bad = 0;
        prev = '0;

        @(posedge clk); #1;
        start  = 1'b1;
        amount = AMT_W'(amt);
        @(posedge clk); #1;
        start = 1'b0;
        cyc   = 1;
        while (!finished && cyc < TIMEOUT) begin
            cur = {o_ej_20, o_ej_10, o_ej_5, o_ej_1};
            if ($countones(cur) > 1) multi = 1;
            if (cur != 0 && prev == 0) begin
                obs_coins.push_back(cur[3] ? 20 : cur[2] ? 10 : cur[1] ? 5 : 1);
                obs_cyc.push_back(cyc);
                hi_len = 1;
            end else if (cur != 0) begin
                if (cur != prev) badw = 1;
                hi_len++;
            end else if (prev != 0 && hi_len != P_CYC) begin
                badw = 1;
            end
            if (done_cyc >= 0 && cyc == done_cyc + 1) begin
                busy_after = busy;
                held_bad   = (int'(short) != obs_short) || (int'(unpaid) != obs_unpaid);
                finished   = 1;
            end else begin
                if (!busy) busy_gap = 1;
                if (done) begin
                    ndone++;
                    done_cyc   = cyc;
                    obs_short  = int'(short);
                    obs_unpaid = int'(unpaid);
                end
            end
            if (repulse && (cyc == 3 || cyc == 10 || cyc == exp_done)) begin
                start  = 1'b1;
                amount = AMT_W'($urandom_range(1, 255));
            end else begin
                start = 1'b0;
            end
            prev = cur;
            if (!finished) begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        start = 1'b0;

        checks++;
        if (!finished) begin
            failures++;
            $display("FAIL %s timeout: no done within %0d cycles (amount %0d)", nm, TIMEOUT, amt);
        end
        checks++;
        if (obs_coins.size() !== exp_coins.size()) begin
            failures++;
            $display("FAIL %s coin_count: got %0d expected %0d", nm, obs_coins.size(), exp_coins.size());
        end
        n = (obs_coins.size() < exp_coins.size()) ? obs_coins.size() : exp_coins.size();
        for (int k = 0; k < n; k++) begin
            checks++;
            if (obs_coins[k] !== exp_coins[k] || obs_cyc[k] !== 2 + k * COIN_CYC) begin
                failures++;
                $display("FAIL %s coin%0d: got %0d@cyc%0d expected %0d@cyc%0d",
                         nm, k, obs_coins[k], obs_cyc[k], exp_coins[k], 2 + k * COIN_CYC);
            end
        end
        checks++;
        if (done_cyc !== exp_done || ndone !== 1) begin
            failures++;
            $display("FAIL %s done: got cyc %0d count %0d expected cyc %0d count 1", nm, done_cyc, ndone, exp_done);
        end
        checks++;
        if (obs_short !== int'(rem != 0) || obs_unpaid !== rem) begin
            failures++;
            $display("FAIL %s residue: got short=%0d unpaid=%0d expected short=%0d unpaid=%0d",
                     nm, obs_short, obs_unpaid, int'(rem != 0), rem);
        end
        checks++;
        if (multi || badw) begin
            failures++;
            $display("FAIL %s eject_shape: got multi_hot=%0d bad_width=%0d expected 0 0", nm, multi, badw);
        end
        checks++;
        if (busy_gap || busy_after !== 1'b0) begin
            failures++;
            $display("FAIL %s busy: got low_while_active=%0d after_done=%0b expected 0 0", nm, busy_gap, busy_after);
        end
        checks++;
        if (held_bad) begin
            failures++;
            $display("FAIL %s hold: short/unpaid changed after done, got %0b/%0d", nm, short, unpaid);
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1; start = 1'b0; amount = '0;
`ifdef INVENTORY_EN
        dep_1 = 0; dep_5 = 0; dep_10 = 0; dep_20 = 0;
`endif
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, short, o_ej_1, o_ej_5, o_ej_10, o_ej_20} !== 7'b0 || unpaid !== '0) begin
            failures++;
            $display("FAIL reset_state: got busy=%b done=%b short=%b ej=%b%b%b%b unpaid=%0d expected all 0",
                     busy, done, short, o_ej_20, o_ej_10, o_ej_5, o_ej_1, unpaid);
        end
        i_rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: busy got %b expected 0", busy);
        end
    endtask

    task automatic test_amount_36();
        run_txn(36, 1'b0, "amt36");
    endtask

    task automatic test_amount_0();
        run_txn(0, 1'b0, "amt0");
    endtask

    task automatic test_back_to_back_ignored();
        run_txn(3, 1'b1, "repulse3");
    endtask

    task automatic test_random();
        for (int t = 0; t < 10; t++) begin
`ifdef INVENTORY_EN
            int m;
            m = $urandom_range(0, 15);
            @(posedge clk); #1;
            {dep_20, dep_10, dep_5, dep_1} = 4'(m);
            for (int i = 0; i < 4; i++) if (m[i] && stock[i] < 255) stock[i]++;
            @(posedge clk); #1;
            {dep_20, dep_10, dep_5, dep_1} = 4'b0;
`endif
            run_txn($urandom_range(0, 255), 1'b0, "random");
        end
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        start = 1'b1; amount = 8'd20;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (o_ej_20 !== 1'b1) begin
            failures++;
            $display("FAIL midrst_pre: o_ej_20 got %b expected 1", o_ej_20);
        end
        #2 i_rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, short, o_ej_1, o_ej_5, o_ej_10, o_ej_20} !== 7'b0 || unpaid !== '0) begin
            failures++;
            $display("FAIL midrst_async: got busy=%b done=%b short=%b ej=%b%b%b%b unpaid=%0d expected all 0",
                     busy, done, short, o_ej_20, o_ej_10, o_ej_5, o_ej_1, unpaid);
        end
        model_reset();
        @(posedge clk); #1;
        i_rst = 1'b0;
        run_txn(5, 1'b0, "after_rst5");
    endtask

`ifdef INVENTORY_EN
    task automatic deposit_ones(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            dep_1 = 1'b1;
            if (stock[0] < 255) stock[0]++;
            @(posedge clk); #1;
            dep_1 = 1'b0;
        end
    endtask

    task automatic test_inventory();
        @(posedge clk); #1;
        i_rst = 1'b1;
        model_reset();
        @(posedge clk); #1;
        i_rst = 1'b0;
        run_txn(160, 1'b0, "inv_drain20");
        run_txn(40, 1'b0, "inv_tens");
        run_txn(4, 1'b0, "inv_ones_a");
        run_txn(4, 1'b0, "inv_ones_b");
        run_txn(3, 1'b0, "inv_short");
        deposit_ones(3);
        run_txn(3, 1'b0, "inv_refill");
    endtask
`endif

    initial begin
        test_reset();
        test_amount_36();
        test_amount_0();
        test_back_to_back_ignored();
        test_random();
        test_reset_mid();
`ifdef INVENTORY_EN
        test_inventory();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/change_dispenser.md
# change_dispenser

Dispenses change or refunds as individual coin-eject pulses. The controller requests an amount; the block pays it out greedily in 20/10/5/1 units, one coin at a time, with fixed pulse and gap widths that the coin hopper can follow. It is the outbound counterpart of the coin-acceptance path. It can also track per-denomination coin stock, fed from the acceptor's registered coin pulses.

## Interface
- AMT_W, 8, width of amount and unpaid.
- PULSE_CYCLES, 2, eject pulse width in clocks (≥1).
- GAP_CYCLES, 4, all-ejects-low gap after each pulse (≥1).
- INIT_STOCK, 8, per-denomination stock after reset (INVENTORY_EN only).
- clk  in  1  clock; all logic on rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- start  in  1  request strobe; sampled only in IDLE.
- amount  in  AMT_W  value to pay, captured with start.
- busy  out  1  high from SELECT through DONE inclusive.
- done  out  1  one-cycle pulse; unpaid and short are valid in that cycle.
- short  out  1  amount could not be paid in full; held until next start.
- unpaid  out  AMT_W  residue not paid; held until next start.
- o_ej_1, o_ej_5, o_ej_10, o_ej_20  out  1 each  coin eject pulses; at most one high at a time.
- dep_1, dep_5, dep_10, dep_20  in  1 each  one-cycle deposit pulses that increment stock (INVENTORY_EN only).

## Operation
- States: IDLE, SELECT, PULSE, GAP, DONE.
- IDLE, start=1: load remaining←amount, clear short and unpaid, go to SELECT.
- SELECT:
  - remaining==0: go to DONE, short=0.
  - Otherwise pick the largest d∈{20,10,5,1} with remaining≥d (and stock[d]>0 under INVENTORY_EN).
  - If a d is found: remaining←remaining−d, stock[d]−1, go to PULSE.
  - If none is found: short←1, go to DONE.
- PULSE: o_ej_d high for PULSE_CYCLES, then go to GAP.
- GAP: all ejects low for GAP_CYCLES, then go to SELECT.
- DONE: done=1, unpaid←remaining, go to IDLE.
- start outside IDLE is ignored; there is no queueing.
- Arithmetic: remaining is unsigned AMT_W and never underflows, because d≤remaining is checked first.
- Stock counters are 8-bit and saturate at 255.
  - A deposit and a dispense of the same denomination in the same cycle give a net 0 change.
  - Several dep_* in one cycle all count.
- Reset (async, also mid-dispense) gives:
  - state IDLE;
  - busy, done, short and all o_ej_* = 0;
  - unpaid = 0 and remaining = 0;
  - stock = INIT_STOCK.
- A pulse cut by reset is not re-issued.

## Timing
- All outputs are registered.
- Start sampled at edge 0: SELECT and busy=1 in cycle 1.
- Each coin costs PULSE_CYCLES + GAP_CYCLES + 1 cycles (pulse, gap, reselect).
- For N coins, done asserts in cycle 2 + N·(PULSE_CYCLES + GAP_CYCLES + 1).
  - With defaults: amount 0 gives done at cycle 2; one coin gives done at cycle 9.
- First eject goes high in cycle 2.
- busy falls the cycle after done; start is accepted again in that cycle.

## Configuration
- INVENTORY_EN defined:
  - stock counters, dep_* ports and INIT_STOCK exist;
  - SELECT skips empty denominations;
  - short can assert for nonzero residue.
- INVENTORY_EN undefined:
  - stock is unlimited, dep_* ports are absent;
  - short is tied 0 and unpaid is always 0 at done.

## Structure
- Shared package vend_pkg holds:
  - denomination constants DENOM_1/5/10/20;
  - the dispense state enum;
  - the one-hot coin index type also used by money acceptance.
- One sub-module, dispense_timer: a loadable down-counter with expire flag, used for both PULSE and GAP. The FSM and stock logic stay in change_dispenser.

## Test plan
- amount=36, defaults → ejects 20,10,5,1 in that order, each 2 cycles high with 4-cycle gaps; done in cycle 30; short=0; unpaid=0.
- amount=0 → no ejects; done in cycle 2; busy high cycles 1–2 only.
- start re-pulsed during a dispense of amount=3 → ignored; exactly three o_ej_1 pulses; one done.
- INVENTORY_EN, stock20=0, stock10=8, amount=40 → four o_ej_10 pulses; stock10 ends at 4.
- INVENTORY_EN, stock1=0, amount=3 → no ejects; done in cycle 2 with short=1, unpaid=3. Then dep_1×3 and retry → three o_ej_1 pulses, short=0.
- i_rst asserted while o_ej_20 is high → all outputs 0 immediately; busy=0; next start with amount=5 gives a single o_ej_5.
